// File: rtl/mac_issue.sv
`timescale 1ns/1ps
// mac_issue
// Issue sequencer at the head of the mac_col chain. A job replays load_beats
// key vectors (col_inst=01) followed by num_q query vectors (col_inst=10) to
// column 0. It then counts the psum writes returned by the last column and
// pulses done once every query has come back.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         begin a job (sampled only in IDLE)
//   skip_load     with start: skip the key phase (keys already resident)
//   num_q         with start: number of query beats
//   in_data       upstream vector, pr*bw bits
//   in_valid      in_data valid
//   in_ready      a beat is accepted this cycle when in_valid is also high
//   col_q         registered vector to column 0 q_in
//   col_inst      registered instruction to column 0 ([1] execute, [0] load)
//   fifo_wr_last  fifo_wr of the last column in the chain
//   busy          high in every state except IDLE
//   done          one-cycle pulse at job completion
module mac_issue #(
    parameter int bw         = 4,
    parameter int pr         = 8,
    parameter int col        = 8,
    parameter int load_beats = 10,
    parameter int qcnt_bw    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 skip_load,
    input  logic [qcnt_bw-1:0]   num_q,
    input  logic [pr*bw-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [pr*bw-1:0]     col_q,
    output logic [1:0]           col_inst,
    input  logic                 fifo_wr_last,
    output logic                 busy,
    output logic                 done
);

    localparam int VW  = pr * bw;
    localparam int LBW = $clog2(load_beats + 1);
    localparam int BCW = (LBW > qcnt_bw) ? LBW : qcnt_bw;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [BCW-1:0] LOAD_N    = BCW'(load_beats);
    localparam logic [BCW-1:0] LOAD_LAST = BCW'(load_beats - 1);

    // Key beat k lands in column load_beats-1-k, so every column needs a beat.
    if (col > load_beats) begin : g_cfg_check
        $error("mac_issue: load_beats must be at least col");
    end

    logic [1:0]         state_q, state_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [qcnt_bw-1:0] ret_cnt_q, ret_cnt_d;
    logic [qcnt_bw-1:0] num_q_q, num_q_d;
    logic [VW-1:0]      col_q_q, col_q_d;
    logic [1:0]         col_inst_q, col_inst_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [BCW-1:0]     num_q_ext;
    logic [BCW-1:0]     beat_inc;

    assign num_q_ext = BCW'(num_q_q);
    assign beat_inc  = beat_cnt_q + BCW'(1);

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_LOAD: in_ready = (beat_cnt_q < LOAD_N);
            ST_EXEC: in_ready = (beat_cnt_q < num_q_ext);
            default: in_ready = 1'b0;
        endcase
    end

    assign xfer = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        ret_cnt_d  = ret_cnt_q;
        num_q_d    = num_q_q;
        col_q_d    = col_q_q;
        col_inst_d = 2'b00;
        done_d     = 1'b0;

        // A bubble issues a no-op and leaves the vector in place.
        if (xfer) begin
            col_q_d    = in_data;
            col_inst_d = (state_q == ST_LOAD) ? 2'b01 : 2'b10;
            beat_cnt_d = beat_inc;
        end

        // Returns only count once queries can be in flight; saturate at the job size.
        if ((state_q == ST_EXEC || state_q == ST_DRAIN) && fifo_wr_last &&
            (ret_cnt_q < num_q_q)) begin
            ret_cnt_d = ret_cnt_q + qcnt_bw'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_q_d    = num_q;
                    beat_cnt_d = '0;
                    ret_cnt_d  = '0;
                    state_d    = skip_load ? ST_EXEC : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer && beat_cnt_q == LOAD_LAST) begin
                    beat_cnt_d = '0;
                    state_d    = (num_q_q != '0) ? ST_EXEC : ST_DRAIN;
                end
            end
            ST_EXEC: begin
                // Second arm covers a skip-load job with zero queries.
                if (xfer && beat_inc == num_q_ext) begin
                    state_d = ST_DRAIN;
                end else if (beat_cnt_q >= num_q_ext) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                if (ret_cnt_q == num_q_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            ret_cnt_q  <= '0;
            num_q_q    <= '0;
            col_q_q    <= '0;
            col_inst_q <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            num_q_q    <= num_q_d;
            col_q_q    <= col_q_d;
            col_inst_q <= col_inst_d;
            done_q     <= done_d;
        end
    end

    assign col_q    = col_q_q;
    assign col_inst = col_inst_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_mac_issue.sv
`timescale 1ns/1ps
module tb_mac_issue;

    localparam int BW         = 4;
    localparam int PR         = 8;
    localparam int COL        = 8;
    localparam int LOAD_BEATS = 10;
    localparam int QCNT_BW    = 6;
    localparam int VW         = PR * BW;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               skip_load = 1'b0;
    logic [QCNT_BW-1:0] num_q = '0;
    logic [VW-1:0]      in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [VW-1:0]      col_q;
    logic [1:0]         col_inst;
    logic               fifo_wr_last;
    logic               busy;
    logic               done;

    logic               inj = 1'b0;
    logic [COL+1:0]     ret_sr = '0;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int n_load_obs = 0;
    int n_exec_obs = 0;
    int done_cnt = 0;
    logic [VW-1:0]   last_q = '0;
    logic [VW+1:0]   sb_q[$];

    mac_issue #(
        .bw(BW), .pr(PR), .col(COL), .load_beats(LOAD_BEATS), .qcnt_bw(QCNT_BW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .skip_load(skip_load),
        .num_q(num_q),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .col_q(col_q),
        .col_inst(col_inst),
        .fifo_wr_last(fifo_wr_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: an execute cycle at column 0 returns fifo_wr from the last
    // column col+2 cycles later.
    always @(posedge clk) begin
        if (!reset) ret_sr <= '0;
        else        ret_sr <= {ret_sr[COL:0], col_inst[1]};
    end
    assign fifo_wr_last = ret_sr[COL+1] | inj;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every issued instruction pops the scoreboard, bubbles hold col_q.
    always @(negedge clk) begin
        logic [VW+1:0] exp;
        if (!reset) begin
            last_q = '0;
        end else begin
            if (col_inst != 2'b00) begin
                check_eq("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check_eq("col_inst", col_inst, exp[VW+1:VW]);
                    check_eq("col_q", col_q, exp[VW-1:0]);
                end
                if (col_inst == 2'b01) n_load_obs++;
                if (col_inst == 2'b10) n_exec_obs++;
            end else begin
                check_eq("bubble_hold", col_q, last_q);
            end
            last_q = col_q;
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_job(input bit skip, input int nq, input bit gaps, input bit ramp,
                           input bit inj_load, input bit start_mid);
        int nl, total, idx, budget, start_cyc, first_cyc, last_cyc, done_cyc;
        bit sm_done, inj_done, got_done;
        nl = skip ? 0 : LOAD_BEATS;
        total = nl + nq;
        idx = 0; budget = 0; first_cyc = -1; last_cyc = 0; done_cyc = 0;
        sm_done = 0; inj_done = 0; got_done = 0;
        n_load_obs = 0; n_exec_obs = 0; done_cnt = 0;

        @(negedge clk);
        start = 1'b1; skip_load = skip; num_q = QCNT_BW'(nq); start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);

        while (idx < total && budget < 200) begin
            start = 1'b0;
            num_q = QCNT_BW'(nq);
            if (start_mid && !sm_done && idx == nl + 1) begin
                start = 1'b1;
                num_q = QCNT_BW'(7);
                sm_done = 1;
            end
            inj = inj_load && !inj_done && idx == 3;
            if (inj) inj_done = 1;
            in_valid = !(gaps && (budget % 3 == 1));
            in_data = ramp ? (32'h11111111 * idx) : $urandom;
            #1;
            if (in_valid && in_ready) begin
                sb_q.push_back({(idx < nl) ? 2'b01 : 2'b10, in_data});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0; num_q = QCNT_BW'(nq); inj = 1'b0; in_valid = 1'b0;

        check_eq("beats_fed", idx, total);
        if (!gaps) begin
            check_eq("first_xfer_lat", first_cyc - start_cyc, 1);
            check_eq("xfer_span", last_cyc - first_cyc, total - 1);
        end

        budget = 0;
        while (!got_done && budget < 60) begin
            #1;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
                budget++;
            end
        end
        check_eq("done_seen", got_done, 1);
        check_eq("done_latency", done_cyc - last_cyc, (nq == 0) ? 2 : COL + 5);

        repeat (3) @(negedge clk);
        #1;
        check_eq("done_pulses", done_cnt, 1);
        check_eq("load_beats_out", n_load_obs, nl);
        check_eq("exec_beats_out", n_exec_obs, nq);
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic reset_mid_job();
        int idx, budget;
        idx = 0; budget = 0;
        @(negedge clk);
        start = 1'b1; skip_load = 1'b1; num_q = QCNT_BW'(5);
        @(negedge clk);
        start = 1'b0;
        while (idx < 2 && budget < 20) begin
            in_valid = 1'b1;
            in_data = $urandom;
            #1;
            if (in_ready) begin
                sb_q.push_back({2'b10, in_data});
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        check_eq("rst_beats_fed", idx, 2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_col_inst", col_inst, 0);
        check_eq("rst_col_q", col_q, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_done", done, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_col_inst", col_inst, 0);
        check_eq("reset_col_q", col_q, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // A return pulse while idle must not be counted.
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        check_eq("ret_idle", dut.ret_cnt_q, 0);
        check_eq("idle_no_busy", busy, 0);

        run_job(1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0);  // full job, ramp data
        run_job(1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b1);  // bubbles, LOAD return pulse, start mid-EXEC
        run_job(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);  // skip load
        run_job(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // zero queries
        reset_mid_job();
        run_job(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);  // clean job after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
